// File: rtl/acq_line_sequencer.sv
// Per-sweep A-line write sequencer for a two-bank ping-pong buffer with DDR2 hand-off.
// Build option: define ACQ_CONTINUOUS_EN to repeat frames without re-arming.
module acq_line_sequencer #(
  parameter int NSAMPLES = 1170,
  parameter int NLINES   = 512
) (
  input  logic        clock,
  input  logic        sclr,
  input  logic        arm,
  input  logic        abort,
  input  logic        trigger,
  input  logic [1:0]  line_ack,
  output logic [10:0] sample_position,
  output logic        wr_en,
  output logic        wr_bank,
  output logic [1:0]  line_ready,
  output logic [9:0]  line_count,
  output logic        frame_done,
  output logic        busy,
  output logic        overrun
);

  localparam logic [10:0] LAST_SAMPLE = 11'(NSAMPLES - 1);
  localparam logic [9:0]  LAST_LINE   = 10'(NLINES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_TRIG,
    S_CAPTURE,
    S_HANDOFF
  } state_t;

  state_t      r_state, w_state_next;
  logic        r_trig_d;
  logic        w_rise;
  logic [10:0] r_pos, w_pos_next;
  logic        r_wr_en, w_wr_en_next;
  logic        r_wr_bank, w_wr_bank_next;
  logic [1:0]  r_line_ready, w_line_ready_next;
  logic [9:0]  r_line_count, w_line_count_next;
  logic        r_frame_done, w_frame_done_next;
  logic        r_overrun, w_overrun_next;

  assign w_rise = trigger & ~r_trig_d;

  always_ff @(posedge clock) begin
    if (sclr) begin
      r_state      <= S_IDLE;
      r_trig_d     <= 1'b0;
      r_pos        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_bank    <= 1'b0;
      r_line_ready <= '0;
      r_line_count <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_trig_d     <= trigger;
      r_pos        <= w_pos_next;
      r_wr_en      <= w_wr_en_next;
      r_wr_bank    <= w_wr_bank_next;
      r_line_ready <= w_line_ready_next;
      r_line_count <= w_line_count_next;
      r_frame_done <= w_frame_done_next;
      r_overrun    <= w_overrun_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_pos_next        = r_pos;
    w_wr_en_next      = r_wr_en;
    w_wr_bank_next    = r_wr_bank;
    w_line_count_next = r_line_count;
    w_frame_done_next = 1'b0;
    w_overrun_next    = r_overrun;
    // Acks drain in every state; a bank is never acked and set in the same cycle.
    w_line_ready_next = r_line_ready & ~line_ack;

    if (abort) begin
      w_state_next = S_IDLE;
      w_wr_en_next = 1'b0;
      w_pos_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Frame state is cleared at arm so pending flags and overrun survive an abort.
          if (arm) begin
            w_state_next      = S_WAIT_TRIG;
            w_line_count_next = '0;
            w_wr_bank_next    = 1'b0;
            w_overrun_next    = 1'b0;
          end
        end
        S_WAIT_TRIG: begin
          if (w_rise) begin
            if (r_line_ready[r_wr_bank]) begin
              w_overrun_next = 1'b1;
            end else begin
              w_state_next = S_CAPTURE;
              w_pos_next   = '0;
              w_wr_en_next = 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          if (r_pos == LAST_SAMPLE) begin
            w_state_next = S_HANDOFF;
            w_pos_next   = '0;
            w_wr_en_next = 1'b0;
          end else begin
            w_pos_next = r_pos + 11'd1;
          end
        end
        S_HANDOFF: begin
          w_line_ready_next[r_wr_bank] = 1'b1;
          w_wr_bank_next = ~r_wr_bank;
          if (r_line_count == LAST_LINE) begin
            w_frame_done_next = 1'b1;
            w_line_count_next = '0;
`ifdef ACQ_CONTINUOUS_EN
            w_state_next = S_WAIT_TRIG;
`else
            w_state_next = S_IDLE;
`endif
          end else begin
            w_line_count_next = r_line_count + 10'd1;
            w_state_next      = S_WAIT_TRIG;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  assign sample_position = r_pos;
  assign wr_en           = r_wr_en;
  assign wr_bank         = r_wr_bank;
  assign line_ready      = r_line_ready;
  assign line_count      = r_line_count;
  assign frame_done      = r_frame_done;
  assign overrun         = r_overrun;
  assign busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_acq_line_sequencer.sv
// Scoreboard bench for acq_line_sequencer with NSAMPLES=8, NLINES=2.
module tb_acq_line_sequencer;
  localparam int NS = 8;
  localparam int NL = 2;

  logic        clock = 1'b0;
  logic        sclr = 1'b0, arm = 1'b0, abort = 1'b0, trigger = 1'b0;
  logic [1:0]  line_ack = 2'b00;
  logic [10:0] sample_position;
  logic        wr_en, wr_bank, frame_done, busy, overrun;
  logic [1:0]  line_ready;
  logic [9:0]  line_count;

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_w;

`ifdef ACQ_CONTINUOUS_EN
  localparam logic END_BUSY = 1'b1;
`else
  localparam logic END_BUSY = 1'b0;
`endif

  acq_line_sequencer #(.NSAMPLES(NS), .NLINES(NL)) dut (
    .clock(clock), .sclr(sclr), .arm(arm), .abort(abort), .trigger(trigger),
    .line_ack(line_ack), .sample_position(sample_position), .wr_en(wr_en),
    .wr_bank(wr_bank), .line_ready(line_ready), .line_count(line_count),
    .frame_done(frame_done), .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

  // Every buffer write is checked against the scoreboard.
  always @(negedge clock) begin
    if (wr_en === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got bank=%0d pos=%0d, required no write", wr_bank, sample_position);
      end else begin
        exp_w = exp_q.pop_front();
        if ({wr_bank, sample_position} !== exp_w) begin
          n_err++;
          $display("FAIL write_addr: got bank=%0d pos=%0d, required bank=%0d pos=%0d",
                   wr_bank, sample_position, exp_w[11], exp_w[10:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_line(input logic bank, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({bank, 11'(i)});
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic ack(input logic [1:0] a);
    line_ack = a; tick(); line_ack = 2'b00;
  endtask

  task automatic check_status(input string name, input logic [1:0] rdy, input logic [9:0] cnt,
                              input logic bank, input logic ovr, input logic bsy);
    n_vec++;
    if ({line_ready, line_count, wr_bank, overrun, busy} !== {rdy, cnt, bank, ovr, bsy}) begin
      n_err++;
      $display("FAIL %s: got ready=%b count=%0d bank=%0d overrun=%b busy=%b, required ready=%b count=%0d bank=%0d overrun=%b busy=%b",
               name, line_ready, line_count, wr_bank, overrun, busy, rdy, cnt, bank, ovr, bsy);
    end
  endtask

  // Full line: trigger rise, NS writes, then the hand-off edge.
  task automatic capture_line(input logic bank);
    push_line(bank, NS);
    trigger = 1'b1; tick(); trigger = 1'b0;
    n_vec++;
    if (wr_en !== 1'b1 || sample_position !== 11'd0) begin
      n_err++;
      $display("FAIL trig_latency: got wr_en=%b pos=%0d, required wr_en=1 pos=0", wr_en, sample_position);
    end
    repeat (NS) tick();
    n_vec++;
    if (wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL wr_en_length: got wr_en=%b after %0d cycles, required 0", wr_en, NS);
    end
    tick();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL write_count: got %0d writes missing, required 0", exp_q.size());
      exp_q.delete();
    end
    $display("line captured on bank %0d, ready=%b count=%0d", bank, line_ready, line_count);
  endtask

  task automatic test_reset();
    sclr = 1'b1; tick(); sclr = 1'b0;
    n_vec++;
    if ({sample_position, wr_en, wr_bank, line_ready, line_count, frame_done, busy, overrun} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got pos=%0d wr_en=%b bank=%b ready=%b count=%0d fd=%b busy=%b ovr=%b, required all 0",
               sample_position, wr_en, wr_bank, line_ready, line_count, frame_done, busy, overrun);
    end
    $display("reset applied");
  endtask

  task automatic test_frame();
    pulse_arm();
    check_status("arm_busy", 2'b00, 10'd0, 1'b0, 1'b0, 1'b1);
    capture_line(1'b0);
    check_status("line0_status", 2'b01, 10'd1, 1'b1, 1'b0, 1'b1);
    capture_line(1'b1);
    n_vec++;
    if (frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL frame_done_pulse: got %b, required 1", frame_done);
    end
    check_status("frame_end", 2'b11, 10'd0, 1'b0, 1'b0, END_BUSY);
    tick();
    n_vec++;
    if (frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL frame_done_width: got %b, required 0", frame_done);
    end
  endtask

  task automatic test_trigger_hold();
    ack(2'b11);
    pulse_arm();
    push_line(1'b0, NS);
    trigger = 1'b1; tick();
    n_vec++;
    if (wr_en !== 1'b1 || sample_position !== 11'd0) begin
      n_err++;
      $display("FAIL hold_latency: got wr_en=%b pos=%0d, required wr_en=1 pos=0", wr_en, sample_position);
    end
    for (int i = 1; i < 20; i++) begin
      trigger = (i != 3);
      tick();
    end
    trigger = 1'b0;
    tick();
    n_vec++;
    if (exp_q.size() != 0 || wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL hold_writes: got %0d missing wr_en=%b, required 0 missing wr_en=0", exp_q.size(), wr_en);
      exp_q.delete();
    end
    check_status("hold_status", 2'b01, 10'd1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_overrun();
    capture_line(1'b1);
    check_status("frame2_end", 2'b11, 10'd0, 1'b0, 1'b0, END_BUSY);
    pulse_arm();
    trigger = 1'b1; tick(); trigger = 1'b0;
    repeat (3) tick();
    check_status("overrun_set", 2'b11, 10'd0, 1'b0, 1'b1, 1'b1);
    ack(2'b01);
    check_status("ack_bank0", 2'b10, 10'd0, 1'b0, 1'b1, 1'b1);
    capture_line(1'b0);
    check_status("after_overrun", 2'b11, 10'd1, 1'b1, 1'b1, 1'b1);
    $display("overrun scenario done");
  endtask

  task automatic test_abort();
    ack(2'b10);
    push_line(1'b1, 4);
    trigger = 1'b1; tick(); trigger = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (sample_position !== 11'd3) begin
      n_err++;
      $display("FAIL abort_setup: got pos=%0d, required 3", sample_position);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    n_vec++;
    if (wr_en !== 1'b0 || sample_position !== 11'd0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL abort_stop: got wr_en=%b pos=%0d missing=%0d, required 0 0 0", wr_en, sample_position, exp_q.size());
      exp_q.delete();
    end
    check_status("abort_status", 2'b01, 10'd1, 1'b1, 1'b1, 1'b0);
    $display("abort at sample 3 done");
  endtask

  task automatic test_sclr();
    pulse_arm();
    ack(2'b01);
    capture_line(1'b0);
    capture_line(1'b1);
    ack(2'b01);
    check_status("pre_sclr", 2'b10, 10'd0, 1'b0, 1'b0, END_BUSY);
    pulse_arm();
    push_line(1'b0, 3);
    trigger = 1'b1; tick(); trigger = 1'b0;
    repeat (2) tick();
    sclr = 1'b1; tick(); sclr = 1'b0;
    n_vec++;
    if ({sample_position, wr_en, wr_bank, line_ready, line_count, frame_done, busy, overrun} !== '0
        || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sclr_outputs: got pos=%0d wr_en=%b ready=%b busy=%b missing=%0d, required all 0",
               sample_position, wr_en, line_ready, busy, exp_q.size());
      exp_q.delete();
    end
    trigger = 1'b1; tick(); trigger = 1'b0;
    repeat (10) tick();
    check_status("no_arm_trigger", 2'b00, 10'd0, 1'b0, 1'b0, 1'b0);
    $display("sclr mid-capture done");
  endtask

  initial begin
    test_reset();
    test_frame();
    test_trigger_hold();
    test_overrun();
    test_abort();
    test_sclr();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/acq_line_sequencer.md
Name: acq_line_sequencer

Overview:
- Sequences one B-scan of SS-OCT acquisition.
- Waits for each sweep trigger, then generates the per-sample write address and write enable into a two-bank (ping-pong) A-line buffer.
- Counts A-lines per frame and hands each completed line to the DDR2 writer with a per-bank ready/ack handshake.
- Sits between the 50 kHz sweep trigger source / ADC capture path and the DDR2 write controller.

Parameters:
- NSAMPLES, 1170, samples written per A-line (1..2047).
- NLINES, 512, A-lines per frame (1..1024).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- sclr  in  1  synchronous, active-high reset.
- arm  in  1  one-cycle pulse; starts a frame from IDLE.
- abort  in  1  level; forces return to IDLE.
- trigger  in  1  sweep trigger, synchronous to clock; rising edge detected internally.
- line_ack  in  2  one-hot per-bank ack from the DDR2 writer.
- sample_position  out  11  buffer write address.
- wr_en  out  1  buffer write enable.
- wr_bank  out  1  bank being written.
- line_ready  out  2  per-bank "line complete, not yet consumed" flags.
- line_count  out  10  A-lines accepted in the current frame.
- frame_done  out  1  one-cycle pulse at end of frame.
- busy  out  1  high in any state except IDLE.
- overrun  out  1  sticky; a trigger was dropped because its bank was still pending.

Behaviour:
- Reset: sclr high at a clock edge clears all registers on that edge. State=IDLE; all outputs 0; internal trigger delay register 0. sclr overrides every other input, including mid-capture.
- Edge detect: trig_d <= trigger; rise = trigger & ~trig_d.
- IDLE:
  - arm=1 -> WAIT_TRIG.
  - Clear line_count, wr_bank and overrun.
- WAIT_TRIG:
  - If rise=1 and line_ready[wr_bank]=0 -> CAPTURE. sample_position<=0, wr_en<=1.
  - If rise=1 and line_ready[wr_bank]=1 -> stay in WAIT_TRIG, overrun<=1. The line is not counted.
- CAPTURE:
  - wr_en stays high for exactly NSAMPLES consecutive cycles, with sample_position running 0..NSAMPLES-1 (+1 per cycle).
  - On the cycle sample_position==NSAMPLES-1: wr_en<=0, sample_position<=0, next state HANDOFF.
  - Triggers during CAPTURE are ignored.
- HANDOFF (exactly 1 cycle):
  - line_ready[wr_bank]<=1.
  - wr_bank<=~wr_bank.
  - line_count<=line_count+1.
  - If line_count==NLINES-1: frame_done pulses, line_count<=0, and the state goes to the end-of-frame destination (see Optional Feature). Otherwise -> WAIT_TRIG.
- Trigger latency: a rise seen at edge k makes wr_en=1, sample_position=0 visible after edge k, i.e. one cycle after the trigger's first high sample.
- line_ack:
  - line_ack[b]=1 clears line_ready[b] on the next edge.
  - Ack of a non-pending bank: no effect.
  - Both bits may be set together.
  - Ack and set can never target the same bank in the same cycle, because a bank is only written while not pending.
- abort:
  - From any state, the next state is IDLE.
  - wr_en and sample_position are cleared at that edge.
  - A partial line is discarded: no line_ready, no count.
  - line_ready flags and overrun are retained so the DDR2 writer can drain.
- arm outside IDLE: ignored.
- Counter widths: line_count is 10 bits. NLINES=1024 ends at count 1023 with no overflow, since the counter returns to 0 in HANDOFF.

Optional Feature:
- Macro ACQ_CONTINUOUS_EN.
- Defined: after the last line, HANDOFF goes to WAIT_TRIG. Frames repeat without re-arming until abort or sclr. frame_done pulses once per frame. overrun is not cleared between frames.
- Undefined: after the last line, HANDOFF goes to IDLE and busy drops on the following cycle. A new arm is required for the next frame.

Test Plan:
- NSAMPLES=8, NLINES=2, arm then trigger rise -> wr_en high exactly 8 cycles, addresses 0..7 starting the cycle after the rise, wr_bank=0. Then line_ready=2'b01, line_count=1.
- Second trigger with bank 1 free -> addresses 0..7 with wr_bank=1, then line_ready=2'b11. frame_done pulses once; busy=0 (macro undefined) or state WAIT_TRIG and line_count=0 (macro defined).
- No ack for bank 0, third trigger in continuous mode -> no wr_en, overrun=1, line_count unchanged. Ack bank 0, next trigger -> capture proceeds.
- Trigger held high for 20 cycles, plus extra rises during CAPTURE -> exactly one line captured (8 writes), no overrun.
- abort at sample_position=3 -> IDLE next cycle, wr_en=0, sample_position=0, line_ready and line_count unchanged.
- sclr asserted mid-capture with line_ready=2'b10 -> all outputs 0 next cycle. A subsequent trigger without arm writes nothing.
